bsg_link_sdr_downstream: RTL and testbench
==========================================

# bsg_link_sdr_downstream

Parametrised single-clock receive side of the link. It accepts CHANNELS narrow io lanes, gearboxes each lane's two consecutive valid beats into one 2*CH_WIDTH word, and buffers words in a per-channel FIFO. It presents the concatenated channel words to the core with a valid/yumi handshake and returns credit tokens upstream once per 2^LG_CREDIT_TO_TOKEN dequeues. Compared with the DDR downstream, it adds arbitrary channel count, width and depth, configurable token batching, and per-channel sticky overflow detection.

## Interface
- CHANNELS, 2, number of io lanes.
- CH_WIDTH, 8, io data bits per lane per beat.
- LG_FIFO_DEPTH, 3, log2 of words per channel FIFO.
- LG_CREDIT_TO_TOKEN, 2, log2 of dequeues per token toggle.
- clk  in  1  clock. Single clock domain.
- rst  in  1  reset. Synchronous, active-high.
- io_valid_i  in  CHANNELS  per-lane beat valid.
- io_data_i  in  CHANNELS*CH_WIDTH  lane c occupies bits [c*CH_WIDTH +: CH_WIDTH].
- core_data_o  out  CHANNELS*2*CH_WIDTH  channel c head word at [c*2*CH_WIDTH +: 2*CH_WIDTH].
- core_valid_o  out  1  every channel FIFO is non-empty.
- core_yumi_i  in  1  core consumes the current word.
- core_token_r_o  out  CHANNELS  toggling credit tokens, one per channel.
- overflow_o  out  CHANNELS  sticky flag: a word was dropped because the FIFO was full.

## Operation
- Per-channel gearbox: a 1-bit phase and a CH_WIDTH low-half register.
  - phase 0 with a valid beat: store the beat as the low half; phase becomes 1.
  - phase 1 with a valid beat: form the word {beat, low}, attempt to enqueue it, and return phase to 0.
  - io_valid_i low: phase and low-half register hold. Beats need not be consecutive.
- Enqueue acceptance uses the pre-edge state:
  - accepted when the FIFO is not full, or when it is full and a dequeue occurs in the same cycle;
  - otherwise the word is dropped and overflow_o[c] is set. overflow_o clears only on rst.
- FIFO pointers are LG_FIFO_DEPTH+1 bits binary.
  - empty: pointers are equal.
  - full: MSBs differ and the low bits are equal.
  - Wrap-around is natural modulo 2^(LG_FIFO_DEPTH+1).
- A dequeue happens when core_valid_o && core_yumi_i.
  - All channels dequeue together.
  - core_yumi_i while core_valid_o is low is ignored: no pointer movement and no count.
- Token generation:
  - One shared LG_CREDIT_TO_TOKEN-bit counter increments on each dequeue.
  - When it wraps from all-ones to 0, every core_token_r_o bit toggles.
  - With LG_CREDIT_TO_TOKEN=0, tokens toggle on every dequeue.
- Reset values: phase 0, pointers 0, counter 0, core_token_r_o 0, overflow_o 0, core_valid_o 0.
  - core_data_o is don't-care while core_valid_o is 0.
- rst mid-operation: partial half-words and buffered words are discarded; nothing is dequeued.

## Timing
- Second beat at cycle t: the word is written at the edge ending t and is visible at cycle t+1. If all other channels are non-empty, core_valid_o rises at t+1.
- core_data_o is combinational from the FIFO head entries. There is no added register stage.
- Dequeue at cycle t: the next head appears at t+1. A token toggle takes effect at t+1.
- Simultaneous enqueue and dequeue on an empty FIFO: the dequeue is not possible (core_valid_o is 0), so only the enqueue occurs.
- Simultaneous enqueue and dequeue on a full FIFO: both occur, and the occupancy is unchanged.

## Structure
- Shared package bsg_link_sdr_pkg holds:
  - localparam helpers for the word width (2*CH_WIDTH) and pointer width;
  - the gearbox phase encoding, a 1-bit enum with values LOW_HALF and HIGH_HALF.
- Sub-module bsg_link_sdr_rx_fifo, one instance per channel. It contains the gearbox, FIFO storage, pointers and overflow flag.
- The top level holds the valid AND-reduction, dequeue fan-out, token counter and token registers.

## Test plan
All scenarios use the default parameters (CHANNELS=2, CH_WIDTH=8, LG_FIFO_DEPTH=3, LG_CREDIT_TO_TOKEN=2).
- Gearbox:
  - Stimulus: lane0 beats 0x34 then 0x12; lane1 beats 0x78 then 0x56.
  - Response: core_valid_o=1 in the next cycle; core_data_o=0x5678_1234.
- Skew:
  - Stimulus: lane0 completes a word at cycle 2; lane1 completes one at cycle 6, with idle gaps between beats.
  - Response: core_valid_o stays 0 until cycle 7, then data is correct.
- Full and overflow:
  - Stimulus: 9 words into both channels with yumi held at 0.
  - Response: overflow_o=2'b11. The next 8 dequeues return the first 8 words in order. The FIFO is then empty.
- Full with simultaneous dequeue:
  - Stimulus: FIFO full, then a 9th word arrives in the same cycle as a yumi.
  - Response: the word is accepted; overflow_o stays 0; occupancy stays 8.
- Tokens:
  - Stimulus: 8 dequeues.
  - Response: core_token_r_o toggles to 2'b11 after the 4th dequeue and back to 2'b00 after the 8th. A yumi while core_valid_o is 0 does not advance the counter.
- Reset mid-operation:
  - Stimulus: assert rst after one lane0 beat and with 3 words buffered.
  - Response: the next cycle shows core_valid_o=0, tokens=0 and overflow=0. A fresh two-beat sequence produces the correct word.

Source files
------------

// File: rtl/bsg_link_sdr_pkg.sv
// Shared definitions for the SDR link receive path: word/pointer width helpers
// and the gearbox phase encoding.
package bsg_link_sdr_pkg;

    typedef enum logic {
        LOW_HALF  = 1'b0,
        HIGH_HALF = 1'b1
    } phase_e;

    function automatic int word_width(input int ch_width);
        return 2 * ch_width;
    endfunction

    // One extra bit distinguishes full from empty when the low bits match.
    function automatic int ptr_width(input int lg_fifo_depth);
        return lg_fifo_depth + 1;
    endfunction

endpackage

// File: rtl/bsg_link_sdr_rx_fifo.sv
// One receive channel: two-beat gearbox feeding a word FIFO with sticky
// overflow detection.
module bsg_link_sdr_rx_fifo
    import bsg_link_sdr_pkg::*;
#(
    parameter int CH_WIDTH      = 8,
    parameter int LG_FIFO_DEPTH = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          beat_valid,
    input  logic [CH_WIDTH-1:0]           beat_data,
    input  logic                          deq,
    output logic [word_width(CH_WIDTH)-1:0] head,
    output logic                          empty,
    output logic                          overflow
);

    localparam int WW    = word_width(CH_WIDTH);
    localparam int PW    = ptr_width(LG_FIFO_DEPTH);
    localparam int DEPTH = 1 << LG_FIFO_DEPTH;

    phase_e                phase;
    logic [CH_WIDTH-1:0]   low;
    logic [WW-1:0]         mem [DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic                  full;
    logic                  word_ready;
    logic                  enq;

    assign empty      = (wptr == rptr);
    assign full       = (wptr[PW-1] != rptr[PW-1]) && (wptr[PW-2:0] == rptr[PW-2:0]);
    assign word_ready = beat_valid && (phase == HIGH_HALF);
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign enq        = word_ready && (!full || deq);
    assign head       = mem[rptr[PW-2:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= LOW_HALF;
            low      <= '0;
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (beat_valid) begin
                phase <= (phase == LOW_HALF) ? HIGH_HALF : LOW_HALF;
                if (phase == LOW_HALF)
                    low <= beat_data;
            end
            if (enq)
                wptr <= wptr + PW'(1);
            if (deq)
                rptr <= rptr + PW'(1);
            if (word_ready && !enq)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq)
            mem[wptr[PW-2:0]] <= {beat_data, low};
    end

endmodule

// File: rtl/bsg_link_sdr_downstream.sv
// SDR link receive side: per-channel gearbox FIFOs, joint valid/yumi dequeue
// and batched credit-token return.
module bsg_link_sdr_downstream
    import bsg_link_sdr_pkg::*;
#(
    parameter int CHANNELS           = 2,
    parameter int CH_WIDTH           = 8,
    parameter int LG_FIFO_DEPTH      = 3,
    parameter int LG_CREDIT_TO_TOKEN = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [CHANNELS-1:0]                     io_valid_i,
    input  logic [CHANNELS*CH_WIDTH-1:0]            io_data_i,
    output logic [CHANNELS*word_width(CH_WIDTH)-1:0] core_data_o,
    output logic                                    core_valid_o,
    input  logic                                    core_yumi_i,
    output logic [CHANNELS-1:0]                     core_token_r_o,
    output logic [CHANNELS-1:0]                     overflow_o
);

    localparam int WW = word_width(CH_WIDTH);

    logic [CHANNELS-1:0] empty;
    logic                deq;

    assign core_valid_o = ~|empty;
    assign deq          = core_valid_o && core_yumi_i;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        bsg_link_sdr_rx_fifo #(
            .CH_WIDTH      (CH_WIDTH),
            .LG_FIFO_DEPTH (LG_FIFO_DEPTH)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .beat_valid (io_valid_i[c]),
            .beat_data  (io_data_i[c*CH_WIDTH +: CH_WIDTH]),
            .deq        (deq),
            .head       (core_data_o[c*WW +: WW]),
            .empty      (empty[c]),
            .overflow   (overflow_o[c])
        );
    end

    if (LG_CREDIT_TO_TOKEN == 0) begin : g_tok_every
        always_ff @(posedge clk) begin
            if (rst)
                core_token_r_o <= '0;
            else if (deq)
                core_token_r_o <= ~core_token_r_o;
        end
    end else begin : g_tok_batched
        logic [LG_CREDIT_TO_TOKEN-1:0] credit_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                credit_cnt     <= '0;
                core_token_r_o <= '0;
            end else if (deq) begin
                credit_cnt <= credit_cnt + LG_CREDIT_TO_TOKEN'(1);
                if (&credit_cnt)
                    core_token_r_o <= ~core_token_r_o;
            end
        end
    end

endmodule

// File: tb/tb_bsg_link_sdr_downstream.sv
// Directed bench for bsg_link_sdr_downstream at default parameters.
module tb_bsg_link_sdr_downstream;

    logic        clk;
    logic        rst;
    logic [1:0]  io_valid_i;
    logic [15:0] io_data_i;
    logic [31:0] core_data_o;
    logic        core_valid_o;
    logic        core_yumi_i;
    logic [1:0]  core_token_r_o;
    logic [1:0]  overflow_o;

    int checks;
    int errors;

    bsg_link_sdr_downstream #(
        .CHANNELS           (2),
        .CH_WIDTH           (8),
        .LG_FIFO_DEPTH      (3),
        .LG_CREDIT_TO_TOKEN (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .io_valid_i     (io_valid_i),
        .io_data_i      (io_data_i),
        .core_data_o    (core_data_o),
        .core_valid_o   (core_valid_o),
        .core_yumi_i    (core_yumi_i),
        .core_token_r_o (core_token_r_o),
        .overflow_o     (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, step past the edge, then return to idle.
    task automatic beat(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                        input logic y);
        io_valid_i  = v;
        io_data_i   = {d1, d0};
        core_yumi_i = y;
        @(posedge clk);
        #1;
        io_valid_i  = '0;
        io_data_i   = '0;
        core_yumi_i = 1'b0;
    endtask

    task automatic word2(input logic [15:0] w0, input logic [15:0] w1, input logic y);
        beat(2'b11, w0[7:0], w1[7:0], 1'b0);
        beat(2'b11, w0[15:8], w1[15:8], y);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [1:0] skew_v [7];
    logic [7:0] skew_d0 [7];
    logic [7:0] skew_d1 [7];

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        io_valid_i = '0;
        io_data_i = '0;
        core_yumi_i = 1'b0;

        // Reset state
        do_reset();
        check("rst_valid", 64'(core_valid_o), 64'd0);
        check("rst_token", 64'(core_token_r_o), 64'd0);
        check("rst_ovf", 64'(overflow_o), 64'd0);

        // Gearbox
        beat(2'b11, 8'h34, 8'h78, 1'b0);
        check("gb_half_valid", 64'(core_valid_o), 64'd0);
        beat(2'b11, 8'h12, 8'h56, 1'b0);
        check("gb_valid", 64'(core_valid_o), 64'd1);
        check("gb_data", 64'(core_data_o), 64'h5678_1234);
        beat(2'b00, 8'h00, 8'h00, 1'b1);
        check("gb_drained", 64'(core_valid_o), 64'd0);

        // Skew: lane0 word done at cycle 2, lane1 at cycle 6
        do_reset();
        skew_v  = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b10};
        skew_d0 = '{8'hAA, 8'h00, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00};
        skew_d1 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hCC, 8'h00, 8'hDD};
        for (int i = 0; i < 7; i++) begin
            beat(skew_v[i], skew_d0[i], skew_d1[i], 1'b0);
            if (i < 6)
                check($sformatf("skew_valid_c%0d", i + 1), 64'(core_valid_o), 64'd0);
        end
        check("skew_valid_c7", 64'(core_valid_o), 64'd1);
        check("skew_data", 64'(core_data_o), 64'hDDCC_BBAA);

        // Full, overflow, in-order drain and token batching
        do_reset();
        for (int k = 0; k < 9; k++) begin
            word2(16'h1000 + 16'(k), 16'h2000 + 16'(k), 1'b0);
            if (k == 7)
                check("full_no_ovf", 64'(overflow_o), 64'd0);
        end
        check("ovf_set", 64'(overflow_o), 64'd3);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("drain_valid%0d", k), 64'(core_valid_o), 64'd1);
            check($sformatf("drain_data%0d", k), 64'(core_data_o),
                  64'({16'h2000 + 16'(k), 16'h1000 + 16'(k)}));
            beat(2'b00, 8'h00, 8'h00, 1'b1);
            check($sformatf("token%0d", k + 1), 64'(core_token_r_o),
                  (k >= 3 && k < 7) ? 64'd3 : 64'd0);
        end
        check("drain_empty", 64'(core_valid_o), 64'd0);
        check("ovf_sticky", 64'(overflow_o), 64'd3);
        // Yumi with nothing valid must not advance the credit counter
        beat(2'b00, 8'h00, 8'h00, 1'b1);
        beat(2'b00, 8'h00, 8'h00, 1'b1);
        for (int k = 0; k < 4; k++)
            word2(16'h3000 + 16'(k), 16'h4000 + 16'(k), 1'b0);
        for (int k = 0; k < 3; k++)
            beat(2'b00, 8'h00, 8'h00, 1'b1);
        check("token_idle_yumi", 64'(core_token_r_o), 64'd0);
        beat(2'b00, 8'h00, 8'h00, 1'b1);
        check("token_after4", 64'(core_token_r_o), 64'd3);

        // Full with simultaneous dequeue
        do_reset();
        for (int k = 0; k < 8; k++)
            word2(16'h5000 + 16'(k), 16'h6000 + 16'(k), 1'b0);
        word2(16'h5008, 16'h6008, 1'b1);
        check("fulldeq_ovf", 64'(overflow_o), 64'd0);
        for (int k = 1; k < 9; k++) begin
            check($sformatf("fulldeq_data%0d", k), 64'(core_data_o),
                  64'({16'h6000 + 16'(k), 16'h5000 + 16'(k)}));
            beat(2'b00, 8'h00, 8'h00, 1'b1);
        end
        check("fulldeq_empty", 64'(core_valid_o), 64'd0);

        // Reset mid-operation
        do_reset();
        for (int k = 0; k < 7; k++)
            word2(16'h7000 + 16'(k), 16'h8000 + 16'(k), 1'b0);
        for (int k = 0; k < 4; k++)
            beat(2'b00, 8'h00, 8'h00, 1'b1);
        check("pre_rst_token", 64'(core_token_r_o), 64'd3);
        beat(2'b01, 8'h77, 8'h00, 1'b0);
        do_reset();
        check("mid_rst_valid", 64'(core_valid_o), 64'd0);
        check("mid_rst_token", 64'(core_token_r_o), 64'd0);
        check("mid_rst_ovf", 64'(overflow_o), 64'd0);
        beat(2'b11, 8'h01, 8'h03, 1'b0);
        beat(2'b11, 8'h02, 8'h04, 1'b0);
        check("post_rst_valid", 64'(core_valid_o), 64'd1);
        check("post_rst_data", 64'(core_data_o), 64'h0403_0201);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
